signed_sort_unit: RTL and testbench

//  Consumer side of the signed less-than compare: a sequential sorter that takes DEPTH signed
//  two's-complement operands over a valid/ready stream and sorts them with one compare-and-swap
//  per cycle. It returns them in ascending order over a second valid/ready stream.

---
 rtl/sort_pkg.sv | 22 ++
 rtl/signed_cmp_swap.sv | 24 ++
 rtl/signed_sort_unit.sv | 161 ++++++++++++++++
 tb/tb_signed_sort_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the signed sort unit.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_DEPTH = 4;

    // Index width for a DEPTH-entry array; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/signed_cmp_swap.sv
// Combinational compare-and-swap: orders two signed operands, lo <= hi.
module signed_cmp_swap #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    // Strict signed less-than, so equal operands keep their order.
    always_comb begin
        swapped = ($signed(b) < $signed(a));
        if (swapped) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/signed_sort_unit.sv
// Sequential bubble sorter: loads DEPTH signed operands, sorts with one compare-and-swap
// per cycle on a fixed schedule, then streams them out in ascending order.
module signed_sort_unit
    import sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int IDXW = idx_width(DEPTH);
    localparam logic [IDXW-1:0] IDX_ZERO  = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DEPTH - 1);
    localparam logic [IDXW-1:0] LAST_STEP = IDXW'(DEPTH - 2);

    sort_state_t      state_r;
    sort_state_t      state_nx_s;
    logic [IDXW-1:0]  wr_idx_r;
    logic [IDXW-1:0]  rd_idx_r;
    logic [IDXW-1:0]  pass_r;
    logic [IDXW-1:0]  pair_r;
    logic [IDXW-1:0]  pair_hi_s;
    logic [IDXW-1:0]  rd_nx_s;
    logic [WIDTH-1:0] array_r [DEPTH];
    logic [WIDTH-1:0] cmp_lo_s;
    logic [WIDTH-1:0] cmp_hi_s;
    logic             cmp_swapped_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;

    assign in_ready  = (state_r == LOAD);
    assign busy      = (state_r != LOAD);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;
    assign pair_hi_s  = pair_r + IDX_ONE;
    assign rd_nx_s    = rd_idx_r + IDX_ONE;

    signed_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .a       (array_r[pair_r]),
        .b       (array_r[pair_hi_s]),
        .lo      (cmp_lo_s),
        .hi      (cmp_hi_s),
        .swapped (cmp_swapped_s)
    );

    // Phase state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Phase sequencing: load DEPTH operands, run every pass/pair, drain until the last output.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_fire_s && (wr_idx_r == LAST_IDX)) begin
                    state_nx_s = SORT;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            SORT: begin
                if ((pass_r == LAST_STEP) && (pair_r == LAST_STEP)) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = SORT;
                end
            end
            DRAIN: begin
                if (out_fire_s && out_last_r) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: state_nx_s = LOAD;
        endcase
    end

    // Operand array, schedule counters and registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                array_r[i] <= {WIDTH{1'b0}};
            end
            wr_idx_r    <= IDX_ZERO;
            rd_idx_r    <= IDX_ZERO;
            pass_r      <= IDX_ZERO;
            pair_r      <= IDX_ZERO;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_fire_s) begin
                        array_r[wr_idx_r] <= in_data;
                        wr_idx_r <= (wr_idx_r == LAST_IDX) ? IDX_ZERO : wr_idx_r + IDX_ONE;
                    end
                end
                SORT: begin
                    if (cmp_swapped_s) begin
                        array_r[pair_r]    <= cmp_lo_s;
                        array_r[pair_hi_s] <= cmp_hi_s;
                    end
                    if (pair_r == LAST_STEP) begin
                        pair_r <= IDX_ZERO;
                        pass_r <= (pass_r == LAST_STEP) ? IDX_ZERO : pass_r + IDX_ONE;
                    end else begin
                        pair_r <= pair_hi_s;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle primes the output register from the settled array.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= array_r[rd_idx_r];
                        out_last_r  <= (rd_idx_r == LAST_IDX);
                    end else if (out_fire_s) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= {WIDTH{1'b0}};
                            rd_idx_r    <= IDX_ZERO;
                        end else begin
                            out_data_r <= array_r[rd_nx_s];
                            out_last_r <= (rd_nx_s == LAST_IDX);
                            rd_idx_r   <= rd_nx_s;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_sort_unit.sv
// Scoreboard bench for signed_sort_unit (WIDTH=6, DEPTH=4) with directed jobs.
module tb_signed_sort_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_data;
    logic       out_last;
    logic       busy;

    typedef struct {
        logic [5:0] d;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       held = 1'b0;
    logic [5:0] held_data = 6'd0;
    logic       held_last = 1'b0;

    signed_sort_unit #(.WIDTH(6), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks backpressure hold.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'($signed(out_data)), int'($signed(held_data)));
                chk("hold_last", int'(out_last), int'(held_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'($signed(out_data)), 999);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", int'($signed(out_data)), int'($signed(e.d)));
                    chk("out_last", int'(out_last), int'(e.last));
                end
                held = 1'b0;
            end else if (out_valid) begin
                held      = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Present one operand from posedge+1 and hold it until accepted.
    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'(v);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_job(input int a, input int b, input int c, input int d,
                           input int e0, input int e1, input int e2, input int e3,
                           input int gap, input bit push);
        if (push) begin
            exp_q.push_back('{6'(e0), 1'b0});
            exp_q.push_back('{6'(e1), 1'b0});
            exp_q.push_back('{6'(e2), 1'b0});
            exp_q.push_back('{6'(e3), 1'b1});
        end
        send(a); gap_cycles(gap);
        send(b); gap_cycles(gap);
        send(c); gap_cycles(gap);
        send(d);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int  cycles;
        bit  seen;
        bit  done;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        gap_cycles(2);

        // 1: mixed signs incl. both extremes, with first-output latency
        run_job(5, -3, 31, -32, -32, -3, 5, 31, 0, 1'b1);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("latency", cycles, 10);
        chk("busy_in_drain", int'(busy), 1);
        wait_idle();

        // 2: ties and already-sorted input
        run_job(7, -1, 7, -1, -1, -1, 7, 7, 0, 1'b1);
        wait_idle();
        run_job(0, 1, 2, 3, 0, 1, 2, 3, 1, 1'b1);
        wait_idle();

        // 3: backpressure while -3 is presented
        out_ready = 1'b0;
        run_job(5, -3, 31, -32, -32, -3, 5, 31, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_first_valid", int'(seen), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'($signed(out_data)), -3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // 4: in_valid held high with 9 through SORT and DRAIN
        run_job(-5, 4, -6, 2, -6, -5, 2, 4, 0, 1'b1);
        in_valid = 1'b1;
        in_data  = 6'd9;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("ignore_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready && out_last) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ignore_last_seen", int'(seen), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ignore_back_to_load", int'(in_ready), 1);
        run_job(3, 2, 1, 0, 0, 1, 2, 3, 0, 1'b1);
        wait_idle();

        // 5: reset during SORT cycle 4 discards the job
        run_job(5, -3, 31, -32, 0, 0, 0, 0, 0, 1'b0);
        gap_cycles(3);
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_job(1, 0, -1, -2, -2, -1, 0, 1, 0, 1'b1);
        wait_idle();

        // 6: back-to-back jobs, input gaps, random out_ready
        done = 1'b0;
        fork
            begin
                run_job(10, -20, 3, 3, -20, 3, 3, 10, 2, 1'b1);
                run_job(31, 30, -31, -32, -32, -31, 30, 31, 0, 1'b1);
                run_job(-1, -1, -1, 0, -1, -1, -1, 0, 1, 1'b1);
                wait_idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
